spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  Responder end of the team SPI link (mode 0: SCK idle low, CS active-low, MSB first).
//  Receives an 8-bit command byte on MOSI. bit7=0 is a write, and bits[6:0] are delivered as data.
//  bit7=1 is a read: bits[6:0] are an address, and the slave returns an 8-bit word on MISO.
//  Sits on the peripheral side. SCK/CS/MOSI are asynchronous to i_clk and are oversampled.
// PARAMETERS
//  DATA_WIDTH   8  width of the command byte and of the read response
//  SYNC_STAGES  2  flops per synchronizer on i_sck, i_cs_n, i_mosi (>=2)
//  CNT_WIDTH    4  bit counter width; must hold DATA_WIDTH
// PORTS
//  i_clk       in   1             system clock; one clock domain
//  i_rst       in   1             reset: one clock; reset is synchronous and active-high
//  i_sck       in   1             SPI clock from the master (async)
//  i_cs_n      in   1             chip select, active-low (async)
//  i_mosi      in   1             master-out data, sampled on SCK rise
//  i_tx_data   in   DATA_WIDTH    read response; sampled exactly 2 clk after o_rd_req
//  o_miso      out  1             slave-out data; changes only on detected SCK fall
//  o_rx_data   out  DATA_WIDTH-1  write payload (cmd[6:0]); held until next write
//  o_rx_valid  out  1             1-clk pulse when o_rx_data is updated
//  o_rd_addr   out  DATA_WIDTH-1  read address (cmd[6:0]); held until next read
//  o_rd_req    out  1             1-clk pulse requesting i_tx_data for o_rd_addr
//  o_busy      out  1             1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM=IDLE, counters 0, shift regs 0.
//  - Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector.
//    A pin edge is seen SYNC_STAGES+1 clk later. Requirement: SCK half-period >= SYNC_STAGES+5 clk.
//  - FSM states: IDLE, CMD, RD_WAIT, RD_DATA, DONE.
//    IDLE->CMD: synced cs_n falls. bit_cnt=0.
//    CMD: on each sck rise, shift in mosi (LSB side) and bit_cnt++.
//      When bit_cnt reaches DATA_WIDTH with cmd[7]=0: update o_rx_data, pulse o_rx_valid next clk, go DONE.
//      When bit_cnt reaches DATA_WIDTH with cmd[7]=1: update o_rd_addr, pulse o_rd_req next clk, go RD_WAIT.
//    RD_WAIT: exactly 2 clk after o_rd_req, load i_tx_data into tx shift reg and go RD_DATA.
//      The next sck fall is the master's end-of-command fall.
//    RD_DATA: on each sck fall, o_miso<=tx_sh[MSB], shift left, tx_cnt++.
//      After DATA_WIDTH bits are driven, go DONE. The final bit is held until CS rises.
//    DONE: ignore SCK; o_miso stays at last value; CS rise -> IDLE.
//  - CS rise in any state -> IDLE next clk, with counters cleared and o_miso<=0.
//    An aborted CMD produces no o_rx_valid/o_rd_req. An aborted read discards tx data.
//  - SCK edges seen while CS is high are ignored. An SCK fall during CMD does not shift.
//  - Extra SCK edges beyond the transaction length are ignored (no wrap).
//  - Same-clk CS rise and SCK edge: CS wins (abort).
//  - i_rst mid-transaction: immediate return to reset values. Requirement: master raises CS before the next transfer.
//  - o_miso = 0 outside RD_DATA/DONE-after-read.
// STRUCTURE
//  - Shared package spi_pkg: CMD_RW_BIT=7, SPI_RD=1'b1, FSM state localparams (3-bit).
//  - One sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulses.
//    Instanced for sck and cs_n; mosi is synchronizer-only.
//  - Top: FSM, bit counter, rx/tx shift registers, output registers.
// TESTING
//  - Write: CS low, send 8'h35 at SCK half-period 16 clk.
//    -> o_rx_data=7'h35, one o_rx_valid pulse, o_miso stays 0, o_busy high until CS high.
//  - Read: send 8'hA4, drive i_tx_data=8'hC3 two clk after o_rd_req.
//    -> o_rd_addr=7'h24, master samples 1,1,0,0,0,0,1,1 on the 8 following rises.
//  - Abort: CS high after 5 bits of 8'h12.
//    -> no pulses, o_busy=0 within 4 clk; the next 8'h12 write is received correctly.
//  - Reset mid-read, asserted after 3 MISO bits.
//    -> all outputs 0 next clk; the transfer after a CS toggle works.
//  - Back-to-back: write 8'h01 then read 8'h80 with CS high 2 SCK periods between.
//    -> exactly one o_rx_valid then one o_rd_req, no cross-contamination.
//  - Noise: 20 SCK toggles with CS high -> no pulses, o_busy=0, o_miso=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
// Contents:
//   CMD_RW_BIT  position of the read/write flag in the command byte
//   SPI_RD      value of that flag that selects a read
//   state_t     FSM state encoding (3-bit)
package spi_pkg;

  localparam int       CMD_RW_BIT = 7;
  localparam logic     SPI_RD     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/spi_if.sv
// Bundle of the SPI pins and the host-side handshake of the SPI responder.
// Signal names are seen from the responder: i_* enter it, o_* leave it.
//   i_sck, i_cs_n, i_mosi  SPI pins from the master (asynchronous)
//   i_tx_data              read response supplied by the host
//   o_miso                 SPI data back to the master
//   o_rx_data/o_rx_valid   write payload and its 1-clk strobe
//   o_rd_addr/o_rd_req     read address and its 1-clk request strobe
//   o_busy                 transaction in progress
// Modports: slave (the responder), master (the SPI master plus host side).
interface spi_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_sck;
  logic                  i_cs_n;
  logic                  i_mosi;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  o_miso;
  logic [DATA_WIDTH-2:0] o_rx_data;
  logic                  o_rx_valid;
  logic [DATA_WIDTH-2:0] o_rd_addr;
  logic                  o_rd_req;
  logic                  o_busy;

  modport slave (
    input  i_sck, i_cs_n, i_mosi, i_tx_data,
    output o_miso, o_rx_data, o_rx_valid, o_rd_addr, o_rd_req, o_busy
  );

  modport master (
    output i_sck, i_cs_n, i_mosi, i_tx_data,
    input  o_miso, o_rx_data, o_rx_valid, o_rd_addr, o_rd_req, o_busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous pin followed by a one-flop edge detector.
// Ports:
//   i_clk, i_rst  system clock, synchronous active-high reset
//   pin           asynchronous input
//   rise, fall    1-clk pulses when the synchronized level changes
// A pin edge shows up on rise/fall SYNC_STAGES clk after it happens and is
// acted on by the consumer at the following edge.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: state is updated with non-blocking assignments only, and the
  // synchronous reset is simply the first branch inside the clocked block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder (SCK idle low, CS active-low, MSB first).
// An 8-bit command arrives on MOSI: bit7=0 delivers bits[6:0] as write data,
// bit7=1 treats bits[6:0] as an address and returns a host-supplied word on MISO.
// Ports:
//   i_clk, i_rst  system clock, synchronous active-high reset
//   bus           spi_if.slave: SPI pins plus host handshake (see spi_if.sv)
// SCK, CS and MOSI are oversampled; the SCK half-period must be at least
// SYNC_STAGES+5 clk so a read response is loaded before the first MISO fall.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input logic  i_clk,
  input logic  i_rst,
  spi_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  // Pin conditioning
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .pin   (bus.i_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .pin   (bus.i_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI only needs the level; its delay matches the SCK path so the bit
  // seen with sck_rise is the one the master presented at that rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // FSM and datapath
  state_t                  state;
  logic [CNT_WIDTH-1:0]    bit_cnt;
  logic [CNT_WIDTH-1:0]    tx_cnt;
  logic                    wait_q;
  logic [DATA_WIDTH-1:0]   rx_sh;
  logic [DATA_WIDTH-1:0]   tx_sh;
  logic                    miso_q;
  logic [DATA_WIDTH-2:0]   rx_data_q;
  logic                    rx_valid_q;
  logic [DATA_WIDTH-2:0]   rd_addr_q;
  logic                    rd_req_q;

  // NOTE: every register is assigned in every branch it must keep or change,
  // and the case has a default, so no latch or undefined state can appear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      wait_q     <= 1'b0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_req_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;

      // CS rise has priority over any SCK edge in the same clock: abort.
      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tx_cnt  <= '0;
        wait_q  <= 1'b0;
        rx_sh   <= '0;
        tx_sh   <= '0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
              rx_sh   <= '0;
            end
          end

          ST_CMD: begin
            if (bit_cnt == CNT_FULL) begin
              if (rx_sh[CMD_RW_BIT] == SPI_RD) begin
                rd_addr_q <= rx_sh[DATA_WIDTH-2:0];
                rd_req_q  <= 1'b1;
                wait_q    <= 1'b0;
                state     <= ST_RD_WAIT;
              end else begin
                rx_data_q  <= rx_sh[DATA_WIDTH-2:0];
                rx_valid_q <= 1'b1;
                state      <= ST_DONE;
              end
            end else if (sck_rise) begin
              rx_sh   <= {rx_sh[DATA_WIDTH-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          // The host answers o_rd_req with i_tx_data; it is taken exactly
          // two clocks after the request pulse.
          ST_RD_WAIT: begin
            if (wait_q) begin
              tx_sh  <= bus.i_tx_data;
              tx_cnt <= '0;
              state  <= ST_RD_DATA;
            end else begin
              wait_q <= 1'b1;
            end
          end

          // The first fall here is the master's end-of-command fall, so
          // the MSB is on MISO before the master's first sampling rise.
          ST_RD_DATA: begin
            if (sck_fall) begin
              miso_q <= tx_sh[DATA_WIDTH-1];
              tx_sh  <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
              tx_cnt <= tx_cnt + 1'b1;
              if (tx_cnt == CNT_LAST) begin
                state <= ST_DONE;
              end
            end
          end

          // Holds the last MISO bit; further SCK edges are ignored.
          ST_DONE: begin
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_miso     = miso_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_rd_addr  = rd_addr_q;
  assign bus.o_rd_req   = rd_req_q;
  assign bus.o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 SPI master model plus a host that
// answers read requests, with a scoreboard of expected write payloads and
// read addresses checked whenever the responder strobes them.
module tb_spi_slave;

  localparam int DW   = 8;
  localparam int HALF = 16;

  logic clk;
  logic rst;

  spi_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-2:0] rx_q [$];
  logic [DW-2:0] rd_q [$];
  int            rx_cycles = 0;
  int            rd_cycles = 0;
  logic [DW-1:0] tx_next = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of data MSB first; each bit is a full SCK period. MISO is
  // sampled at every rise, the way a mode-0 master would.
  task automatic spi_bits(input logic [DW-1:0] data, input int nbits,
                          output logic [DW-1:0] sampled);
    sampled = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.i_mosi = data[DW-1-i];
      wait_clk(HALF);
      bus.i_sck = 1'b1;
      sampled = {sampled[DW-2:0], bus.o_miso};
      wait_clk(HALF);
      bus.i_sck = 1'b0;
    end
    bus.i_mosi = 1'b0;
  endtask

  task automatic cs_low();
    bus.i_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    bus.i_cs_n = 1'b1;
  endtask

  // Scoreboard side: compare strobed outputs with what the master sent.
  always @(negedge clk) begin
    logic [DW-2:0] exp_v;
    if (bus.o_rx_valid) begin
      rx_cycles++;
      exp_v = (rx_q.size() != 0) ? rx_q.pop_front() : 7'bxxxxxxx;
      check("rx_data", 32'(bus.o_rx_data), 32'(exp_v));
    end
    if (bus.o_rd_req) begin
      rd_cycles++;
      exp_v = (rd_q.size() != 0) ? rd_q.pop_front() : 7'bxxxxxxx;
      check("rd_addr", 32'(bus.o_rd_addr), 32'(exp_v));
    end
  end

  // Host side: the response is valid only around the clock edge two clk
  // after the request, so any other sampling instant picks up filler.
  always @(negedge clk) begin
    if (bus.o_rd_req) begin
      @(posedge clk);
      @(negedge clk);
      bus.i_tx_data = tx_next;
      @(posedge clk);
      @(negedge clk);
      bus.i_tx_data = 8'h5A;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] got;
    int            rx_base;
    int            rd_base;
    logic          any_busy;
    logic          any_miso;

    bus.i_sck     = 1'b0;
    bus.i_cs_n    = 1'b1;
    bus.i_mosi    = 1'b0;
    bus.i_tx_data = 8'h5A;
    rst           = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);

    // Reset state
    check("rst_miso",     32'(bus.o_miso),     32'd0);
    check("rst_rx_data",  32'(bus.o_rx_data),  32'd0);
    check("rst_rx_valid", 32'(bus.o_rx_valid), 32'd0);
    check("rst_rd_addr",  32'(bus.o_rd_addr),  32'd0);
    check("rst_rd_req",   32'(bus.o_rd_req),   32'd0);
    check("rst_busy",     32'(bus.o_busy),     32'd0);
    wait_clk(10);

    // Write 0x35
    cs_low();
    check("wr_busy_start", 32'(bus.o_busy), 32'd1);
    rx_q.push_back(7'h35);
    spi_bits(8'h35, 8, got);
    check("wr_miso_quiet", 32'(got), 32'd0);
    wait_clk(HALF);
    check("wr_busy_done", 32'(bus.o_busy), 32'd1);
    check("wr_one_pulse", 32'(rx_cycles), 32'd1);
    cs_high();
    wait_clk(6);
    check("wr_busy_end", 32'(bus.o_busy), 32'd0);
    check("wr_rx_held", 32'(bus.o_rx_data), 32'h35);
    wait_clk(2 * HALF);

    // Read 0xA4, response 0xC3
    tx_next = 8'hC3;
    cs_low();
    rd_q.push_back(7'h24);
    spi_bits(8'hA4, 8, got);
    spi_bits(8'h00, 8, got);
    check("rd_bits", 32'(got), 32'hC3);
    check("rd_one_req", 32'(rd_cycles), 32'd1);
    wait_clk(HALF);
    check("rd_last_held", 32'(bus.o_miso), 32'd1);
    check("rd_busy_done", 32'(bus.o_busy), 32'd1);
    cs_high();
    wait_clk(6);
    check("rd_miso_idle", 32'(bus.o_miso), 32'd0);
    check("rd_busy_end", 32'(bus.o_busy), 32'd0);
    wait_clk(2 * HALF);

    // Abort after 5 bits of 0x12, then the full write
    rx_base = rx_cycles;
    rd_base = rd_cycles;
    cs_low();
    spi_bits(8'h12, 5, got);
    cs_high();
    wait_clk(4);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    wait_clk(2 * HALF);
    check("abort_no_rx", 32'(rx_cycles), 32'(rx_base));
    check("abort_no_rd", 32'(rd_cycles), 32'(rd_base));
    cs_low();
    rx_q.push_back(7'h12);
    spi_bits(8'h12, 8, got);
    wait_clk(HALF);
    cs_high();
    wait_clk(6);
    check("abort_retry_rx", 32'(bus.o_rx_data), 32'h12);
    wait_clk(2 * HALF);

    // Reset after 3 MISO bits of a read
    tx_next = 8'h96;
    cs_low();
    rd_q.push_back(7'h55);
    spi_bits(8'hD5, 8, got);
    spi_bits(8'h00, 3, got);
    check("rst_mid_bits", 32'(got[2:0]), 32'b100);
    wait_clk(4);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rst_mid_miso",    32'(bus.o_miso),    32'd0);
    check("rst_mid_rx_data", 32'(bus.o_rx_data), 32'd0);
    check("rst_mid_rd_addr", 32'(bus.o_rd_addr), 32'd0);
    check("rst_mid_busy",    32'(bus.o_busy),    32'd0);
    cs_high();
    wait_clk(2 * HALF);
    cs_low();
    rx_q.push_back(7'h4B);
    spi_bits(8'h4B, 8, got);
    wait_clk(HALF);
    cs_high();
    wait_clk(6);
    check("rst_after_rx", 32'(bus.o_rx_data), 32'h4B);
    wait_clk(2 * HALF);

    // Back-to-back: write 0x01, CS high two SCK periods, read 0x80
    rx_base = rx_cycles;
    rd_base = rd_cycles;
    tx_next = 8'h3C;
    cs_low();
    rx_q.push_back(7'h01);
    spi_bits(8'h01, 8, got);
    wait_clk(HALF);
    cs_high();
    wait_clk(4 * HALF);
    check("b2b_rx_once", 32'(rx_cycles), 32'(rx_base + 1));
    check("b2b_rd_none", 32'(rd_cycles), 32'(rd_base));
    cs_low();
    rd_q.push_back(7'h00);
    spi_bits(8'h80, 8, got);
    spi_bits(8'h00, 8, got);
    check("b2b_rd_bits", 32'(got), 32'h3C);
    wait_clk(HALF);
    cs_high();
    wait_clk(6);
    check("b2b_rd_once", 32'(rd_cycles), 32'(rd_base + 1));
    check("b2b_rx_still", 32'(rx_cycles), 32'(rx_base + 1));
    check("b2b_rx_kept", 32'(bus.o_rx_data), 32'h01);
    wait_clk(2 * HALF);

    // Noise: SCK toggling with CS high
    rx_base  = rx_cycles;
    rd_base  = rd_cycles;
    any_busy = 1'b0;
    any_miso = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.i_sck  = ~bus.i_sck;
      bus.i_mosi = 1'($urandom_range(1, 0));
      for (int j = 0; j < HALF; j++) begin
        wait_clk(1);
        any_busy = any_busy | bus.o_busy;
        any_miso = any_miso | bus.o_miso;
      end
    end
    bus.i_sck  = 1'b0;
    bus.i_mosi = 1'b0;
    wait_clk(HALF);
    check("noise_busy", 32'(any_busy), 32'd0);
    check("noise_miso", 32'(any_miso), 32'd0);
    check("noise_no_rx", 32'(rx_cycles), 32'(rx_base));
    check("noise_no_rd", 32'(rd_cycles), 32'(rd_base));

    // Everything expected was delivered, each as a single-cycle strobe
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("rx_total", 32'(rx_cycles), 32'd4);
    check("rd_total", 32'(rd_cycles), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
